// File: rtl/touch_slider_decoder_pkg.sv
// Shared definitions for the touch slider decoder: FSM encoding, percent
// range and helpers that derive the scaler constant and band edges.
package touch_slider_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CALC1 = 2'd2,
    ST_CALC2 = 2'd3
  } state_e;

  localparam int PCT_W   = 7;
  localparam int PCT_MAX = 100;
  localparam int FRAC_W  = 16;

  // Fixed-point gain so that (x - x_min) * scale >> 16 spans 0..100.
  // Rounded up so X_MAX lands on 100 rather than 99.
  function automatic int scale_f(input int x_min, input int x_max);
    return ((PCT_MAX << FRAC_W) + (x_max - x_min) - 1) / (x_max - x_min);
  endfunction

  // Lower Y edge of band k.
  function automatic int band_lo(input int base, input int pitch, input int k);
    return base + k * pitch;
  endfunction

endpackage

// File: rtl/touch_slider_decoder_band.sv
// Band hit test for one slider: Y inside [LO, HI).
module touch_band_decode #(
  parameter int COORD_W = 12,
  parameter int LO      = 0,
  parameter int HI      = 1
) (
  input  logic [COORD_W-1:0] y,
  output logic               hit
);

  logic [31:0] y_ext;

  // Compare in 32 bits so band edges above the coordinate range never wrap.
  always_comb begin
    y_ext = 32'(y);
    hit   = (y_ext >= 32'(LO)) && (y_ext < 32'(HI));
  end

endmodule

// File: rtl/touch_slider_decoder.sv
// Touch slider decoder: band select, window averaging, two-stage scaler,
// deadband and release/timeout handling for NUM_SLIDERS stacked bars.
module touch_slider_decoder
  import touch_slider_decoder_pkg::*;
#(
  parameter int COORD_W     = 12,
  parameter int NUM_SLIDERS = 2,
  parameter int AVG_LOG2    = 2,
  parameter int X_MIN       = 200,
  parameter int X_MAX       = 3900,
  parameter int Y_BASE      = 300,
  parameter int Y_PITCH     = 1800,
  parameter int Y_HEIGHT    = 1200,
  parameter int DEADBAND    = 1,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                         iCLK,
  input  logic                         iRST_n,
  input  logic                         iPEN_n,
  input  logic                         iSAMPLE_VALID,
  input  logic [COORD_W-1:0]           iX_COORD,
  input  logic [COORD_W-1:0]           iY_COORD,
  output logic [PCT_W*NUM_SLIDERS-1:0] oVALUES,
  output logic                         oUPDATE,
  output logic [2:0]                   oACTIVE,
  output logic                         oTOUCHING
);

  localparam int WIN    = 1 << AVG_LOG2;
  localparam int ACC_W  = COORD_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int PROD_W = COORD_W + 17;
  localparam int SCALE  = scale_f(X_MIN, X_MAX);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Per-slider band decode
  logic [NUM_SLIDERS-1:0] band_hit;
  for (genvar k = 0; k < NUM_SLIDERS; k++) begin : g_band
    touch_band_decode #(
      .COORD_W (COORD_W),
      .LO      (band_lo(Y_BASE, Y_PITCH, k)),
      .HI      (band_lo(Y_BASE, Y_PITCH, k) + Y_HEIGHT)
    ) u_band (
      .y   (iY_COORD),
      .hit (band_hit[k])
    );
  end

  logic       hit_any;
  logic [2:0] hit_idx;

  // Lowest-numbered band wins if bands overlap.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLIDERS - 1; k >= 0; k--) begin
      if (band_hit[k]) begin
        hit_any = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  state_e                       state_q, state_d;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [2:0]                   active_q, active_d;
  logic                         touching_q, touching_d;
  logic [COORD_W-1:0]           mean_q, mean_d;
  logic [2:0]                   calc_idx_q, calc_idx_d;
  logic [PROD_W-1:0]            prod_q, prod_d;
  logic                         rel_q, rel_d;
  logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
  logic                         wr_q, wr_d;
  logic [2:0]                   wr_idx_q, wr_idx_d;
  logic [PCT_W-1:0]             wr_val_q, wr_val_d;
  logic [PCT_W*NUM_SLIDERS-1:0] values_q, values_d;
  logic                         update_q, update_d;

  logic               accept, restart, win_full, take, release_now, sat;
  logic [ACC_W-1:0]   acc_sum, acc_shr;
  logic [CNT_W-1:0]   cnt_sum;
  logic [COORD_W-1:0] x_off;
  logic [COORD_W:0]   p_int;
  logic [PCT_W-1:0]   v, old_v, diff;

  // Next-state: averaging window, FSM, scaler pipeline and output commit
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    touching_d = touching_q;
    mean_d     = mean_q;
    calc_idx_d = calc_idx_q;
    prod_d     = prod_q;
    rel_d      = rel_q;
    to_cnt_d   = to_cnt_q;
    wr_d       = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_val_d   = wr_val_q;
    values_d   = values_q;
    update_d   = 1'b0;
    take        = 1'b0;
    release_now = 1'b0;

    // Pen-up beats a coincident sample.
    accept   = iSAMPLE_VALID && !iPEN_n && hit_any;
    // A cleared window (acc=0, cnt=0) accumulates correctly either way.
    restart  = (hit_idx != active_q);
    acc_sum  = restart ? ACC_W'(iX_COORD) : acc_q + ACC_W'(iX_COORD);
    cnt_sum  = restart ? CNT_W'(1) : cnt_q + CNT_W'(1);
    win_full = (cnt_sum == CNT_W'(WIN));
    acc_shr  = acc_sum >> AVG_LOG2;

    x_off = (mean_q < COORD_W'(X_MIN)) ? '0 : mean_q - COORD_W'(X_MIN);
    p_int = prod_q[PROD_W-1:FRAC_W];
    sat   = (p_int > (COORD_W+1)'(PCT_MAX));
    v     = sat ? PCT_W'(PCT_MAX) : p_int[PCT_W-1:0];
    old_v = '0;
    for (int k = 0; k < NUM_SLIDERS; k++)
      if (3'(k) == calc_idx_q) old_v = values_q[PCT_W*k +: PCT_W];
    diff  = (v > old_v) ? v - old_v : old_v - v;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          take       = 1'b1;
          touching_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (iPEN_n || (!accept && to_cnt_q == TO_LAST)) begin
          release_now = 1'b1;
        end else if (accept) begin
          take     = 1'b1;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_CALC1: begin
        prod_d  = PROD_W'(x_off) * PROD_W'(SCALE);
        state_d = ST_CALC2;
        // A window can't close here: the mean register is still in use.
        if (iPEN_n) begin
          rel_d = 1'b1;
        end else if (accept && !rel_q && !win_full) begin
          take     = 1'b1;
          to_cnt_d = '0;
        end
      end
      ST_CALC2: begin
        wr_d     = (32'(diff) >= 32'(DEADBAND)) && (diff != '0);
        wr_idx_d = calc_idx_q;
        wr_val_d = v;
        if (iPEN_n || rel_q) begin
          release_now = 1'b1;
        end else begin
          state_d = ST_ACCUM;
          if (accept) begin
            take     = 1'b1;
            to_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      active_d = hit_idx;
      if (win_full) begin
        mean_d     = acc_shr[COORD_W-1:0];
        calc_idx_d = hit_idx;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = ST_CALC1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_sum;
      end
    end

    if (release_now) begin
      state_d    = ST_IDLE;
      acc_d      = '0;
      cnt_d      = '0;
      touching_d = 1'b0;
      rel_d      = 1'b0;
      to_cnt_d   = '0;
    end

    // Field and pulse change together, one cycle after CALC2.
    if (wr_q) begin
      update_d = 1'b1;
      for (int k = 0; k < NUM_SLIDERS; k++)
        if (3'(k) == wr_idx_q) values_d[PCT_W*k +: PCT_W] = wr_val_q;
    end
  end

  // State registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      touching_q <= 1'b0;
      mean_q     <= '0;
      calc_idx_q <= '0;
      prod_q     <= '0;
      rel_q      <= 1'b0;
      to_cnt_q   <= '0;
      wr_q       <= 1'b0;
      wr_idx_q   <= '0;
      wr_val_q   <= '0;
      values_q   <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      touching_q <= touching_d;
      mean_q     <= mean_d;
      calc_idx_q <= calc_idx_d;
      prod_q     <= prod_d;
      rel_q      <= rel_d;
      to_cnt_q   <= to_cnt_d;
      wr_q       <= wr_d;
      wr_idx_q   <= wr_idx_d;
      wr_val_q   <= wr_val_d;
      values_q   <= values_d;
      update_q   <= update_d;
    end
  end

  assign oVALUES   = values_q;
  assign oUPDATE   = update_q;
  assign oACTIVE   = active_q;
  assign oTOUCHING = touching_q;

endmodule

// File: tb/tb_touch_slider_decoder.sv
// Scoreboard bench: stimulus pushes expected oVALUES/cycle for each update,
// an independent monitor pops on every oUPDATE pulse.
module tb_touch_slider_decoder;

  localparam int TOC = 300;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iPEN_n = 1'b1;
  logic        iSAMPLE_VALID = 1'b0;
  logic [11:0] iX_COORD = '0;
  logic [11:0] iY_COORD = '0;
  logic [13:0] oVALUES;
  logic        oUPDATE;
  logic [2:0]  oACTIVE;
  logic        oTOUCHING;

  touch_slider_decoder #(.TIMEOUT_CYC(TOC)) dut (
    .iCLK          (iCLK),
    .iRST_n        (iRST_n),
    .iPEN_n        (iPEN_n),
    .iSAMPLE_VALID (iSAMPLE_VALID),
    .iX_COORD      (iX_COORD),
    .iY_COORD      (iY_COORD),
    .oVALUES       (oVALUES),
    .oUPDATE       (oUPDATE),
    .oACTIVE       (oACTIVE),
    .oTOUCHING     (oTOUCHING)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] vals;
    int          at;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] pk(input int s0, input int s1);
    logic [6:0] a, b;
    a = 7'(s0);
    b = 7'(s1);
    return {b, a};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the next expected entry.
  always @(negedge iCLK) begin
    if (oUPDATE) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update at cycle %0d values %h", cyc, oVALUES);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (oVALUES !== e.vals || cyc != e.at) begin
          errors++;
          $display("FAIL update values %h cycle %0d want values %h cycle %0d",
                   oVALUES, cyc, e.vals, e.at);
        end
      end
    end
  end

  // One sample, captured on the posedge between two negedges.
  task automatic send(input int x, input int y);
    @(negedge iCLK);
    iSAMPLE_VALID = 1'b1;
    iX_COORD = 12'(x);
    iY_COORD = 12'(y);
    @(negedge iCLK);
    iSAMPLE_VALID = 1'b0;
  endtask

  // Call right after the sample that closes a window.
  task automatic expect_upd(input int s0, input int s1);
    exp_t e;
    e.vals = pk(s0, s1);
    e.at   = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic window(input int x, input int y);
    for (int i = 0; i < 4; i++) send(x, y);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  initial begin
    idle(3);
    chk("reset_values", int'(oVALUES), 0);
    chk("reset_update", int'(oUPDATE), 0);
    chk("reset_active", int'(oACTIVE), 0);
    chk("reset_touching", int'(oTOUCHING), 0);
    iRST_n = 1'b1;
    iPEN_n = 1'b0;
    idle(2);

    // 1: midpoint on slider 0 -> 50
    send(2050, 800);
    chk("t1_touching", int'(oTOUCHING), 1);
    chk("t1_active", int'(oACTIVE), 0);
    for (int i = 0; i < 3; i++) send(2050, 800);
    expect_upd(50, 0);
    idle(6);

    // 2: slider 1 clamps at 100, then below X_MIN gives 0
    window(4095, 2500);
    expect_upd(50, 100);
    chk("t2_active", int'(oACTIVE), 1);
    idle(6);
    window(100, 2500);
    expect_upd(50, 0);
    idle(6);

    // 3: gap samples interleaved are rejected
    for (int i = 0; i < 4; i++) begin
      send(1000, 1700);
      send(3900, 2500);
    end
    expect_upd(50, 100);
    idle(6);

    // 4: partial window on slider 0 abandoned for slider 1
    send(3000, 800);
    send(3000, 800);
    chk("t4_active0", int'(oACTIVE), 0);
    window(2050, 2500);
    expect_upd(50, 50);
    chk("t4_active1", int'(oACTIVE), 1);
    idle(6);

    // 5: same value suppressed, +1 passes the deadband
    window(2050, 800);
    idle(6);
    window(2087, 800);
    expect_upd(51, 50);
    idle(6);
    chk("t5_values", int'(oVALUES), int'(pk(51, 50)));

    // 5b: pen-up mid-window drops the partial window
    send(3900, 800);
    send(3900, 800);
    @(negedge iCLK);
    iPEN_n = 1'b1;
    idle(3);
    chk("t5_release_touching", int'(oTOUCHING), 0);
    chk("t5_release_values", int'(oVALUES), int'(pk(51, 50)));
    iPEN_n = 1'b0;
    send(3900, 800);
    send(3900, 800);
    idle(6);

    // 6: timeout after TOC cycles without an in-band sample
    chk("t6_touching_pre", int'(oTOUCHING), 1);
    idle(TOC - 20);
    chk("t6_touching_before_to", int'(oTOUCHING), 1);
    idle(30);
    chk("t6_touching_after_to", int'(oTOUCHING), 0);
    send(3900, 800);
    send(3900, 800);
    idle(6);

    // 6b: reset while the scaler is in CALC1 -> no write
    send(4095, 800);
    send(4095, 800);
    iRST_n = 1'b0;
    #1;
    chk("t6_rst_values", int'(oVALUES), 0);
    chk("t6_rst_touching", int'(oTOUCHING), 0);
    chk("t6_rst_active", int'(oACTIVE), 0);
    idle(2);
    iRST_n = 1'b1;
    idle(8);
    chk("t6_post_rst_values", int'(oVALUES), 0);

    chk("pending_updates", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
